// File: rtl/rgb_to_gray_control_if.sv
// Pixel byte stream in, gray pixel / frame-active / pixel count out.
// The DUT takes the slave side; the source and the Sobel controller take the master side.
interface rgb_to_gray_control_if #(
    parameter int PIXEL_WIDTH_IN      = 8,
    parameter int PIXEL_WIDTH_OUT     = 8,
    parameter int MAX_RESOLUTION_BITS = 16
);
    logic                           in_valid_i;
    logic [PIXEL_WIDTH_IN-1:0]      in_byte_i;
    logic                           in_ready_o;
    logic [PIXEL_WIDTH_OUT-1:0]     out_px_gray_o;
    logic                           px_valid_o;
    logic                           start_o;
    logic [MAX_RESOLUTION_BITS-1:0] px_count_o;

    modport master (
        output in_valid_i, in_byte_i,
        input  in_ready_o, out_px_gray_o, px_valid_o, start_o, px_count_o
    );

    modport slave (
        input  in_valid_i, in_byte_i,
        output in_ready_o, out_px_gray_o, px_valid_o, start_o, px_count_o
    );
endinterface

// File: rtl/rgb_to_gray_control.sv
// Collects R, G, B bytes and emits one 8-bit luminance pixel (77/150/29 weights).
// Define GRAY_ROUNDING_EN for round-to-nearest; the default build truncates.
module rgb_to_gray_control #(
    parameter int PIXEL_WIDTH_IN      = 8,
    parameter int PIXEL_WIDTH_OUT     = 8,
    parameter int MAX_RESOLUTION_BITS = 16
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  start_i,
    rgb_to_gray_control_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        GET_R,
        GET_G,
        GET_B,
        CALC
    } state_e;

    state_e                         state_q, state_d;
    logic [PIXEL_WIDTH_IN-1:0]      r_q, r_d;
    logic [PIXEL_WIDTH_IN-1:0]      g_q, g_d;
    logic [PIXEL_WIDTH_IN-1:0]      b_q, b_d;
    logic [PIXEL_WIDTH_OUT-1:0]     gray_q, gray_d;
    logic                           px_valid_q, px_valid_d;
    logic                           start_q;
    logic [MAX_RESOLUTION_BITS-1:0] count_q, count_d;

    logic        in_ready;
    logic        accept;
    logic [15:0] sum;
    logic [15:0] sum_adj;

    assign in_ready = start_i && (state_q == GET_R || state_q == GET_G || state_q == GET_B);
    assign accept   = in_ready && bus.in_valid_i;

    // Weights total 256, so the 16-bit sum (and the +128 rounding bias) never overflows.
    assign sum = 16'(r_q) * 16'd77 + 16'(g_q) * 16'd150 + 16'(b_q) * 16'd29;
`ifdef GRAY_ROUNDING_EN
    assign sum_adj = sum + 16'd128;
`else
    assign sum_adj = sum;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        gray_d     = gray_q;
        px_valid_d = 1'b0;
        count_d    = count_q;

        if (!start_i) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE:  state_d = GET_R;
                GET_R: if (accept) begin r_d = bus.in_byte_i; state_d = GET_G; end
                GET_G: if (accept) begin g_d = bus.in_byte_i; state_d = GET_B; end
                GET_B: if (accept) begin b_d = bus.in_byte_i; state_d = CALC;  end
                CALC: begin
                    gray_d     = PIXEL_WIDTH_OUT'(sum_adj >> 8);
                    px_valid_d = 1'b1;
                    count_d    = count_q + MAX_RESOLUTION_BITS'(1);
                    state_d    = GET_R;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= IDLE;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            gray_q     <= '0;
            px_valid_q <= 1'b0;
            start_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            gray_q     <= gray_d;
            px_valid_q <= px_valid_d;
            start_q    <= start_i;
            count_q    <= count_d;
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.out_px_gray_o = gray_q;
    assign bus.px_valid_o    = px_valid_q;
    assign bus.start_o       = start_q;
    assign bus.px_count_o    = count_q;

endmodule
